// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response channel and the
// {pc, inst} output channel toward the core.
interface inst_fetch_unit_if #(
    parameter int WORD_LEN = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [WORD_LEN-1:0] imem_req_addr;
    logic                imem_resp_valid;
    logic [WORD_LEN-1:0] imem_resp_data;
    logic                out_valid;
    logic                out_ready;
    logic [WORD_LEN-1:0] out_pc;
    logic [WORD_LEN-1:0] out_inst;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch with credit-limited prefetch FIFO, redirect flush and halt.
// Optional trace output when IFU_FETCH_TRACE_EN is defined.
module inst_fetch_unit #(
    parameter int                   WORD_LEN       = 32,
    parameter int                   FIFO_DEPTH     = 4,
    parameter int                   FIFO_DEPTH_BIT = 2,
    parameter logic [WORD_LEN-1:0]  RESET_VECTOR   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    input  logic                redirect_valid,
    input  logic [WORD_LEN-1:0] redirect_pc,
    inst_fetch_unit_if.master   bus
);
    localparam int CW = FIFO_DEPTH_BIT + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW:0] CREDIT = (CW + 1)'(FIFO_DEPTH);

    logic [WORD_LEN-1:0]       fetch_pc;
    logic [WORD_LEN-1:0]       resp_pc;
    logic [WORD_LEN-1:0]       pc_mem   [FIFO_DEPTH];
    logic [WORD_LEN-1:0]       inst_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BIT-1:0] rd_ptr;
    logic [FIFO_DEPTH_BIT-1:0] wr_ptr;
    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             drop_cnt;

    logic                      in_flight_ok;
    logic                      req_fire;
    logic                      resp_take;
    logic                      push;
    logic                      pop;
    logic [WORD_LEN-1:0]       redirect_aligned;
    logic [CW-1:0]             drop_next;

    assign redirect_aligned = redirect_pc & ~WORD_LEN'(3);
    assign in_flight_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT;

    assign bus.imem_req_valid = !rst && !halt && !redirect_valid && in_flight_ok;
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_take = bus.imem_resp_valid && (outstanding != '0);
    assign push      = resp_take && (drop_cnt == '0) && !redirect_valid;
    assign pop       = bus.out_valid && bus.out_ready && !redirect_valid;
    assign drop_next = outstanding - CW'(resp_take);

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr] : '0;
    assign bus.out_inst  = bus.out_valid ? inst_mem[rd_ptr] : '0;

    // PCs, FIFO pointers and credit counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            if (redirect_valid) begin
                fetch_pc   <= redirect_aligned;
                resp_pc    <= redirect_aligned;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
                drop_cnt   <= drop_next;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + WORD_LEN'(4);
                if (resp_take && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + WORD_LEN'(4);
                    wr_ptr  <= wr_ptr + FIFO_DEPTH_BIT'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + FIFO_DEPTH_BIT'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO payload storage, written at the tail on each accepted response
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= bus.imem_resp_data;
        end
    end

    // catch overflow and unsolicited responses, both memory-side bugs
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_count == FULL));
            assert (!(bus.imem_resp_valid && outstanding == '0));
        end
    end

`ifdef IFU_FETCH_TRACE_EN
    // trace consumed instructions and redirects
    always_ff @(posedge clk) begin
        if (!rst && pop)
            $display("fetch pc: %d inst: 0x%H", bus.out_pc, bus.out_inst);
        if (!rst && redirect_valid)
            $display("redirect -> %d drop: %0d", redirect_aligned, drop_next);
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a latency-configurable
// in-order instruction memory model (inst = addr ^ 32'hDEAD0000).
module tb_inst_fetch_unit;
    logic        clk = 0;
    logic        rst = 0;
    logic        halt = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = '0;

    inst_fetch_unit_if #(.WORD_LEN(32)) bus ();

    inst_fetch_unit #(
        .WORD_LEN(32),
        .FIFO_DEPTH(4),
        .FIFO_DEPTH_BIT(2),
        .RESET_VECTOR(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .halt(halt),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] req_log[$];
    logic [31:0] opc_log[$];
    logic [31:0] oinst_log[$];
    int          lat = 1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        fire;
        logic [31:0] a;
        fire = bus.imem_req_valid && bus.imem_req_ready;
        a = bus.imem_req_addr;
        if (bus.imem_resp_valid)
            void'(mq.pop_front());
        if (bus.out_valid && bus.out_ready && !redirect_valid) begin
            opc_log.push_back(bus.out_pc);
            oinst_log.push_back(bus.out_inst);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            mq.push_back('{addr: a, due: cyc - 1 + lat});
            req_log.push_back(a);
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data = mq[0].addr ^ 32'hDEAD0000;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        halt = 0;
        redirect_valid = 0;
        bus.imem_resp_valid = 0;
        bus.imem_resp_data = '0;
        mq.delete();
        req_log.delete();
        opc_log.delete();
        oinst_log.delete();
        @(posedge clk);
        #1;
        rst = 0;
        cyc = 0;
        #1;
    endtask

    initial begin
        bus.imem_req_ready = 1;
        bus.imem_resp_valid = 0;
        bus.imem_resp_data = '0;
        bus.out_ready = 1;

        // reset state
        #1 rst = 1;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);

        // streaming with 1-cycle memory
        do_reset();
        lat = 1;
        chk("t1_req_valid0", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_req_addr0", bus.imem_req_addr, 32'h0);
        step();
        chk("t1_out_valid1", 32'(bus.out_valid), 32'd0);
        chk("t1_req_addr1", bus.imem_req_addr, 32'h4);
        step();
        chk("t1_out_valid2", 32'(bus.out_valid), 32'd1);
        chk("t1_out_pc2", bus.out_pc, 32'h0);
        chk("t1_out_inst2", bus.out_inst, 32'hDEAD0000);
        for (int k = 3; k < 7; k++) begin
            step();
            chk("t1_out_pc", bus.out_pc, 32'((k - 2) * 4));
            chk("t1_out_inst", bus.out_inst, 32'((k - 2) * 4) ^ 32'hDEAD0000);
        end

        // reset mid-operation clears at once
        rst = 1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);

        // stalled core fills the FIFO, then drains without loss
        do_reset();
        bus.out_ready = 0;
        for (int k = 0; k < 6; k++)
            step();
        chk("t2_req_count", 32'(req_log.size()), 32'd4);
        chk("t2_req_valid_full", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_out_pc_head", bus.out_pc, 32'h0);
        bus.out_ready = 1;
        #1;
        step();
        chk("t2_req_valid_resume", 32'(bus.imem_req_valid), 32'd1);
        chk("t2_req_addr_resume", bus.imem_req_addr, 32'h10);
        for (int k = 0; k < 5; k++)
            step();
        chk("t2_out_count", 32'(opc_log.size()), 32'd6);
        for (int i = 0; i < opc_log.size(); i++)
            chk("t2_out_seq", opc_log[i], 32'(i * 4));
        for (int i = 0; i < req_log.size(); i++)
            chk("t2_req_seq", req_log[i], 32'(i * 4));

        // redirect with 2 in flight on a 3-cycle memory
        do_reset();
        lat = 3;
        step();
        step();
        redirect_valid = 1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_req_valid_redir", 32'(bus.imem_req_valid), 32'd0);
        step();
        redirect_valid = 0;
        #1;
        chk("t3_req_addr_new", bus.imem_req_addr, 32'h100);
        for (int k = 0; k < 4; k++) begin
            chk("t3_no_stale", 32'(bus.out_valid), 32'd0);
            step();
        end
        chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_out_pc", bus.out_pc, 32'h100);
        chk("t3_out_inst", bus.out_inst, 32'hDEAD0100);
        step();
        chk("t3_out_pc_next", bus.out_pc, 32'h104);

        // redirect coinciding with a response and a pop
        do_reset();
        lat = 1;
        step();
        step();
        chk("t4_head_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_head_pc", bus.out_pc, 32'h0);
        redirect_valid = 1;
        redirect_pc = 32'h200;
        #1;
        chk("t4_req_valid_redir", 32'(bus.imem_req_valid), 32'd0);
        step();
        redirect_valid = 0;
        #1;
        chk("t4_flushed", 32'(bus.out_valid), 32'd0);
        chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t4_req_addr", bus.imem_req_addr, 32'h200);
        chk("t4_no_pop_logged", 32'(opc_log.size()), 32'd0);
        step();
        chk("t4_resp_discarded", 32'(bus.out_valid), 32'd0);
        step();
        chk("t4_out_pc", bus.out_pc, 32'h200);

        // halt with 2 outstanding
        do_reset();
        lat = 3;
        step();
        step();
        halt = 1;
        #1;
        chk("t5_req_valid_halt", 32'(bus.imem_req_valid), 32'd0);
        for (int k = 0; k < 8; k++)
            step();
        chk("t5_out_count", 32'(opc_log.size()), 32'd2);
        chk("t5_out_pc0", opc_log[0], 32'h0);
        chk("t5_out_pc1", opc_log[1], 32'h4);
        chk("t5_req_count", 32'(req_log.size()), 32'd2);
        chk("t5_idle_out", 32'(bus.out_valid), 32'd0);
        chk("t5_idle_req", 32'(bus.imem_req_valid), 32'd0);
        redirect_valid = 1;
        redirect_pc = 32'h40;
        #1;
        step();
        redirect_valid = 0;
        #1;
        chk("t5_halt_redir_req", 32'(bus.imem_req_valid), 32'd0);
        halt = 0;
        #1;
        chk("t5_resume_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t5_resume_addr", bus.imem_req_addr, 32'h40);

        // unaligned redirect and address wrap
        do_reset();
        lat = 1;
        redirect_valid = 1;
        redirect_pc = 32'h103;
        #1;
        step();
        redirect_valid = 0;
        #1;
        chk("t6_align_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_align_addr", bus.imem_req_addr, 32'h100);
        step();
        redirect_valid = 1;
        redirect_pc = 32'hFFFFFFFC;
        #1;
        step();
        redirect_valid = 0;
        #1;
        chk("t6_drop_100", 32'(bus.out_valid), 32'd0);
        chk("t6_top_addr", bus.imem_req_addr, 32'hFFFFFFFC);
        step();
        chk("t6_wrap_addr", bus.imem_req_addr, 32'h0);
        step();
        chk("t6_top_out_pc", bus.out_pc, 32'hFFFFFFFC);
        chk("t6_top_out_inst", bus.out_inst, 32'h2152FFFC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle decode/execute core.
- Issues word-aligned fetch requests to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small prefetch FIFO and presents {pc, inst} pairs to the core over a valid/ready channel.
- Supports PC redirect (branch/jump) with flush of buffered and in-flight fetches, and halt (driven by the core's exit).

Parameters:
- WORD_LEN, 32, data/address width
- FIFO_DEPTH, 4, prefetch FIFO entries; also the maximum of (FIFO occupancy + outstanding requests)
- FIFO_DEPTH_BIT, 2, log2(FIFO_DEPTH)
- RESET_VECTOR, 32'h0, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- halt  in  1  stop issuing new requests (core exit)
- redirect_valid  in  1  redirect fetch PC this cycle
- redirect_pc  in  WORD_LEN  new fetch address; bits [1:0] ignored, treated as 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  WORD_LEN  fetch address
- imem_resp_valid  in  1  response valid; in order, one per accepted request, no backpressure
- imem_resp_data  in  WORD_LEN  instruction word
- out_valid  out  1  instruction available to core
- out_ready  in  1  core consumes instruction
- out_pc  out  WORD_LEN  PC of presented instruction
- out_inst  out  WORD_LEN  presented instruction

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_VECTOR, resp_pc=RESET_VECTOR, FIFO empty, outstanding=0, drop_cnt=0. Outputs during reset: imem_req_valid=0, imem_req_addr=RESET_VECTOR, out_valid=0, out_pc=0, out_inst=0.
- Reset mid-operation clears everything immediately. Responses arriving after reset release, for pre-reset requests, are a memory-side violation; the memory is reset together with this block.
- Request: imem_req_valid = !halt && !redirect_valid && (fifo_count + outstanding) < FIFO_DEPTH. imem_req_addr = fetch_pc.
- On request handshake: fetch_pc += 4 (wraps modulo 2^WORD_LEN) and outstanding increments.
- Response:
  - Each response decrements outstanding.
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Else: push {resp_pc, imem_resp_data} into the FIFO and increment resp_pc by 4.
  - The credit rule guarantees a push never finds the FIFO full. Overflow is unreachable and checked by assertion.
- Output:
  - out_valid = FIFO not empty; out_pc/out_inst = FIFO head (first-word fall-through from registered storage).
  - Pop on out_valid && out_ready.
  - Latency: a response accepted in cycle N appears on out_* in cycle N+1. Minimum request-to-out_valid latency with a 1-cycle memory is 2 cycles.
  - Simultaneous push and pop: both take effect; count unchanged.
- Redirect (redirect_valid=1 in cycle N), takes priority over everything:
  - FIFO flushed.
  - Any pop in cycle N is ignored; the core must not treat the head as consumed.
  - No request issued in cycle N.
  - A response arriving in cycle N is discarded.
  - drop_cnt <= outstanding - imem_resp_valid, so all remaining in-flight responses are dropped.
  - fetch_pc and resp_pc <= {redirect_pc[WORD_LEN-1:2], 2'b00}.
  - The first request to the new PC may issue in cycle N+1 if credit allows. Dropped in-flight requests still consume credit until their responses return.
- Back-to-back redirects: each re-flushes; drop_cnt is recomputed from outstanding.
- Halt:
  - Blocks new requests only.
  - Outstanding responses are still accepted and the FIFO still drains.
  - Redirect during halt updates the PCs and flushes.
- Response with outstanding==0: ignored, with an assertion.

Optional Feature:
- Macro IFU_FETCH_TRACE_EN.
- Defined: on every out_* handshake, $display prints "fetch pc: %d inst: 0x%H". On every redirect, $display prints "redirect -> %d" along with the drop count.
- Undefined: no display statements and identical logic.

Test Plan:
- Reset release, 1-cycle memory, out_ready=1 -> requests to 0,4,8,... on consecutive cycles; out_pc=0 appears 2 cycles after the first request, then one instruction per cycle in order.
- out_ready=0, memory always ready -> exactly 4 requests issued (0,4,8,12), FIFO full, imem_req_valid=0. Then out_ready=1 -> fetching resumes at 16 with no lost or duplicated PC.
- 3-cycle memory latency with 2 requests in flight, redirect_pc=0x100 -> both stale responses dropped; next out_pc=0x100 with the correct instruction; the FIFO never contains stale PCs.
- Redirect in the same cycle as a response and a pop -> response discarded, head not consumed, fetch restarts at redirect_pc the next cycle.
- halt=1 while 2 requests are outstanding -> no new requests; both responses delivered to out_*; then out_valid=0 and the block stays idle.
- redirect_pc=0x103 -> fetch issued at 0x100. Then fetch_pc at 0xFFFFFFFC wraps -> next request address is 0x0.
